// File: rtl/pie_cmd_serializer.sv
// Reader command serializer feeding pie_encoder: shifts a latched payload out MSB-first
// on each enc_rdy and appends an EPC Gen2 CRC-5 or CRC-16 trailer.
module pie_cmd_serializer #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_LEN-1:0] cmd_data,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [1:0]         cmd_crc,
  input  logic               cmd_preamble,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic               out_bit,
  input  logic               enc_rdy,
  output logic               out_preamble,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = (LEN_W > 5) ? LEN_W : 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CRC
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         crc_sel_q, crc_sel_d;
  logic [15:0]        crc_q, crc_d;
  logic               out_bit_q, out_bit_d;
  logic               pre_q, pre_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic        crc16, has_crc, fb, last_payload, last_crc, len_ok;
  logic [15:0] crc_upd, crc_tx;

  always_comb begin
    crc16   = (crc_sel_q == 2'b10);
    has_crc = (crc_sel_q == 2'b01) || (crc_sel_q == 2'b10);
    len_ok  = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_LEN));

    // CRC register update with the payload bit currently on out_bit
    if (crc16) begin
      fb      = crc_q[15] ^ sh_q[MAX_LEN-1];
      crc_upd = {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end else begin
      fb      = crc_q[4] ^ sh_q[MAX_LEN-1];
      crc_upd = {11'b0, crc_q[3:0], 1'b0} ^ (fb ? 16'h0009 : 16'h0000);
    end
    // Transmit form, left-aligned so the CRC phase always shifts out bit 15
    crc_tx = crc16 ? ~crc_upd : {crc_upd[4:0], 11'b0};

    last_payload = (cnt_q == CNT_W'(len_q) - CNT_W'(1));
    last_crc     = (cnt_q == (crc16 ? CNT_W'(15) : CNT_W'(4)));
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    crc_sel_d = crc_sel_q;
    crc_d     = crc_q;
    out_bit_d = out_bit_q;
    pre_d     = pre_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        out_bit_d = 1'b0;
        pre_d     = 1'b0;
        if (cmd_valid) begin
          if (len_ok) begin
            state_d   = S_PAYLOAD;
            sh_d      = cmd_data;
            len_d     = cmd_len;
            crc_sel_d = cmd_crc;
            pre_d     = cmd_preamble;
            out_bit_d = cmd_data[MAX_LEN-1];
            cnt_d     = '0;
            crc_d     = (cmd_crc == 2'b10) ? 16'hFFFF : 16'h0009;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_PAYLOAD: begin
        if (enc_rdy) begin
          sh_d      = sh_q << 1;
          crc_d     = crc_upd;
          cnt_d     = cnt_q + CNT_W'(1);
          out_bit_d = sh_d[MAX_LEN-1];
          if (last_payload) begin
            cnt_d = '0;
            if (has_crc) begin
              state_d   = S_CRC;
              crc_d     = crc_tx;
              out_bit_d = crc_tx[15];
            end else begin
              state_d   = S_IDLE;
              done_d    = 1'b1;
              out_bit_d = 1'b0;
              pre_d     = 1'b0;
            end
          end
        end
      end

      S_CRC: begin
        if (enc_rdy) begin
          crc_d     = crc_q << 1;
          cnt_d     = cnt_q + CNT_W'(1);
          out_bit_d = crc_d[15];
          if (last_crc) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            out_bit_d = 1'b0;
            pre_d     = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      crc_sel_q <= '0;
      crc_q     <= '0;
      out_bit_q <= 1'b0;
      pre_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      crc_sel_q <= crc_sel_d;
      crc_q     <= crc_d;
      out_bit_q <= out_bit_d;
      pre_q     <= pre_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign out_bit      = out_bit_q;
  assign out_preamble = pre_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: doc/pie_cmd_serializer.md
Name: pie_cmd_serializer

Overview:
- Reader-side stage directly upstream of pie_encoder.
- Accepts one complete reader command (payload bits, length, CRC type, preamble select) over a valid/ready handshake.
- Serializes the payload MSB-first into the encoder's in_bit/in_rdy bit interface and appends CRC-5 or CRC-16 per EPC Gen2.
- Drives output_pie_preamble so Query-class commands get a full preamble and all others get frame-sync only.

Parameters:
MAX_LEN, 64, maximum payload bits per command
LEN_W, 7, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_data  in  MAX_LEN  payload, left-aligned: first bit sent is cmd_data[MAX_LEN-1]
cmd_len  in  LEN_W  payload bit count, legal range 1..MAX_LEN
cmd_crc  in  2  00 none, 01 CRC-5, 10 CRC-16, 11 treated as none
cmd_preamble  in  1  1 = full preamble (Query), 0 = frame-sync
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
out_bit  out  1  bit to pie_encoder in_bit
enc_rdy  in  1  pie_encoder in_rdy; 1-cycle pulse meaning current out_bit is consumed
out_preamble  out  1  to pie_encoder output_pie_preamble
busy  out  1  frame in progress
done  out  1  1-cycle pulse when the last frame bit is consumed
err  out  1  1-cycle pulse when an illegal cmd_len is accepted

Behaviour:
- Reset (rst=0, async): state IDLE; out_bit=0, out_preamble=0, busy=0, done=0, err=0; cmd_ready=1 after reset release; shift register, counters and CRC cleared. Reset mid-frame aborts immediately with no done pulse.
- Outputs are registered; cmd_ready = (state==IDLE).
- States: IDLE, PAYLOAD, CRC.
- IDLE:
  - enc_rdy is ignored; out_bit=0.
  - On cmd_valid&cmd_ready with 1<=cmd_len<=MAX_LEN: latch cmd_data/len/crc/preamble; next cycle out_bit=cmd_data[MAX_LEN-1], busy=1, out_preamble=latched cmd_preamble, state PAYLOAD.
  - First bit is visible before the first enc_rdy. Accept-to-first-bit latency is 1 cycle.
  - Illegal cmd_len (0 or >MAX_LEN): accepted, err pulses next cycle, no bits emitted, stay IDLE.
- PAYLOAD:
  - Each enc_rdy advances out_bit to the next payload bit on the next cycle.
  - On the enc_rdy consuming payload bit cmd_len-1:
    - crc none: done=1 next cycle, busy=0, out_bit=0, IDLE.
    - Otherwise out_bit = first CRC bit, state CRC.
- CRC:
  - Each enc_rdy advances to the next CRC bit, MSB first.
  - On the enc_rdy consuming the final CRC bit (5th or 16th): done, busy=0, IDLE.
- CRC-5: poly x^5+x^3+1, preset 5'b01001.
  - Per bit: fb=crc[4]^bit; crc={crc[3:0],1'b0}^(fb?5'b01001:0).
  - Transmitted uninverted.
- CRC-16: CCITT poly 0x1021, preset 0xFFFF, same shift form.
  - Transmitted as ones-complement.
- CRC covers exactly the payload bits sent. The final CRC includes the last payload bit at the transition cycle.
- CRC-phase shifting does not further update the CRC.
- out_preamble holds steady for the entire frame and returns to 0 in IDLE.
- enc_rdy with no transition pending has no effect. Back-to-back enc_rdy (every cycle) is supported.
- cmd_valid while busy is not accepted; it must be held by upstream.
- A new command can be accepted in the cycle done is high, because the state is already IDLE.
- Frame length = cmd_len + {0,5,16} enc_rdy pulses.

Test Plan:
- Reset, then cmd_len=4, cmd_data=4'b1011 left-aligned, crc=00, enc_rdy every 5 cycles -> out_bit sequence 1,0,1,1; done one cycle after 4th enc_rdy; busy high throughout.
- cmd_len=1, data=1, crc=01, cmd_preamble=1 -> bits 1,1,1,0,1,1 (CRC-5 = 5'b11011); out_preamble=1 for the whole frame; done after 6th enc_rdy.
- cmd_len=8, data=8'h00, crc=10 -> 8 zeros then 16'h1E0F MSB first (complement of 0xE1F0); done after 24 enc_rdy.
- cmd_len=0 and cmd_len=MAX_LEN+1 -> err pulse, no busy, out_bit stays 0; next legal command works.
- Assert rst low after 3 of 8 bits -> all outputs 0 immediately, no done; a fresh command then restarts from bit 0 with preset CRC.
- Back-to-back: second command held valid during first, enc_rdy every cycle -> accepted on done cycle; first bit of second frame appears one cycle later with no lost or duplicated bits; scoreboard matches.
